fifo_pkt_reader: RTL

FIFO_PKT_READER -- requirements
Module: fifo_pkt_reader

---
 rtl/fifo_pkt_reader_if.sv | 29 ++
 rtl/fifo_pkt_reader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_reader_if.sv
// rtl/fifo_pkt_reader_if.sv - FIFO read side and packet output side of fifo_pkt_reader
interface fifo_pkt_reader_if #(
  parameter int WIDTH = 64,
  parameter int PTR   = 4
) ();
  logic             rdempty;
  logic [PTR:0]     rdusedw;
  logic [WIDTH-1:0] fifo_data;
  logic             rden;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_sop;
  logic             out_eop;
  logic [7:0]       out_be;
  logic             len_err;

  // The reader is the master: it pops the FIFO and sources the packet stream.
  modport master (
    input  rdempty, rdusedw, fifo_data, out_ready,
    output rden, out_valid, out_data, out_sop, out_eop, out_be, len_err
  );

  // FIFO and downstream sink seen from the environment.
  modport slave (
    output rdempty, rdusedw, fifo_data, out_ready,
    input  rden, out_valid, out_data, out_sop, out_eop, out_be, len_err
  );
endinterface

// File: rtl/fifo_pkt_reader.sv
// rtl/fifo_pkt_reader.sv - header-framed FIFO packet reader; optional FIFO_PKT_READER_STATS_EN counters
module fifo_pkt_reader #(
  parameter int          WIDTH   = 64,
  parameter int          PTR     = 4,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic                clk,
  input  logic                reset_,
  fifo_pkt_reader_if.master   bus
`ifdef FIFO_PKT_READER_STATS_EN
  ,
  output logic [31:0]         pkt_cnt,
  output logic [15:0]         err_cnt
`endif
);
  localparam int EW = WIDTH + 10;

  typedef enum logic [1:0] {S_IDLE, S_HDR_WAIT, S_DATA} state_t;

  state_t        r_state, w_next;
  logic [13:0]   r_n;
  logic [13:0]   r_issued;
  logic [7:0]    r_be_last;
  logic          r_inflight;
  logic          r_inf_sop;
  logic          r_inf_eop;
  logic [EW-1:0] r_buf [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_buf_cnt;

  logic          w_rden;
  logic          w_len_err;
  logic          w_rd;
  logic          w_wr;
  logic          w_space;
  logic [15:0]   w_len;
  logic          w_len_ok;
  logic [16:0]   w_len_p7;
  logic [13:0]   w_hdr_n;
  logic [7:0]    w_hdr_be;
  logic [EW-1:0] w_head;

  assign w_len    = bus.fifo_data[15:0];
  assign w_len_ok = (w_len != 16'd0) && (32'(w_len) <= MAX_LEN);
  assign w_len_p7 = {1'b0, w_len} + 17'd7;
  assign w_hdr_n  = w_len_p7[16:3];
  assign w_hdr_be = (w_len[2:0] == 3'd0) ? 8'hFF : ((8'd1 << w_len[2:0]) - 8'd1);

  assign w_head = r_buf[r_rd_ptr];
  assign w_rd   = (r_buf_cnt != 2'd0) && bus.out_ready;
  // Only payload pops land in the buffer; a header pop is always followed by HDR_WAIT.
  assign w_wr   = r_inflight && (r_state == S_DATA);
  // Occupancy counts the entry leaving this cycle as gone, so a full-rate
  // stream keeps popping every cycle without ever exceeding two entries.
  assign w_space = (({1'b0, r_buf_cnt} - {2'b00, w_rd} + {2'b00, r_inflight}) < 3'd2);

  // Next state, pop request and length-error pulse.
  always_comb begin
    w_next    = r_state;
    w_rden    = 1'b0;
    w_len_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.rdempty && w_space) begin
          w_rden = 1'b1;
          w_next = S_HDR_WAIT;
        end
      end
      S_HDR_WAIT: begin
        if (w_len_ok) begin
          w_next = S_DATA;
        end else begin
          w_next    = S_IDLE;
          w_len_err = 1'b1;
        end
      end
      S_DATA: begin
        if (!bus.rdempty && w_space && (r_issued < r_n)) begin
          w_rden = 1'b1;
        end
        if (w_wr && r_inf_eop) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register, header capture and per-packet pop tracking.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_issued   <= '0;
      r_be_last  <= '0;
      r_inflight <= 1'b0;
      r_inf_sop  <= 1'b0;
      r_inf_eop  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_rden;
      if (r_state == S_HDR_WAIT && w_len_ok) begin
        r_n       <= w_hdr_n;
        r_issued  <= '0;
        r_be_last <= w_hdr_be;
      end
      if (w_rden && r_state == S_DATA) begin
        r_issued  <= r_issued + 14'd1;
        r_inf_sop <= (r_issued == 14'd0);
        r_inf_eop <= (r_issued == r_n - 14'd1);
      end
    end
  end

  // Two-entry output buffer holding {data, sop, eop, be}.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_buf[0]  <= '0;
      r_buf[1]  <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_buf_cnt <= 2'd0;
    end else begin
      if (w_wr) begin
        r_buf[r_wr_ptr] <= {bus.fifo_data, r_inf_sop, r_inf_eop,
                            (r_inf_eop ? r_be_last : 8'hFF)};
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_rd) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_buf_cnt <= r_buf_cnt + {1'b0, w_wr} - {1'b0, w_rd};
    end
  end

  // rden is combinational, so it is held low explicitly while reset is asserted.
  assign bus.rden      = w_rden & reset_;
  assign bus.len_err   = w_len_err & reset_;
  assign bus.out_valid = (r_buf_cnt != 2'd0);
  assign bus.out_data  = w_head[EW-1:10];
  assign bus.out_sop   = w_head[9];
  assign bus.out_eop   = w_head[8];
  assign bus.out_be    = w_head[7:0];

`ifdef FIFO_PKT_READER_STATS_EN
  // Wrapping packet and length-error counters.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (w_rd && bus.out_eop) pkt_cnt <= pkt_cnt + 32'd1;
      if (w_len_err)           err_cnt <= err_cnt + 16'd1;
    end
  end
`endif
endmodule
